scope_capture_ctrl: RTL and testbench
=====================================

# scope_capture_ctrl

Capture sequencer for the oscilloscope datapath. It consumes the 8-bit sample stream produced by the serial ADC interface, applies decimation and an edge/level trigger, and writes one frame of samples into the display sample RAM. It then hands the frame to the display side through a ready/ack handshake. Run modes are auto, normal, single and stop.

## Interface
- ADDR_W, 8: sample RAM address width; frame length = 2^ADDR_W samples.
- AUTO_TIMEOUT, 16'd1000: accepted samples in WAIT_TRIG before auto mode forces a trigger; valid range 1..65535.

- CLK_50M  in  1  system clock, 50 MHz.
- RST_N  in  1  reset, asynchronous, active-low.
- sample_valid  in  1  one-cycle pulse per new ADC sample.
- sample_data  in  8  ADC sample, unsigned; valid with sample_valid.
- trig_level  in  8  trigger threshold, unsigned.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = stop.
- arm  in  1  one-cycle pulse; starts one single-mode acquisition.
- decim  in  4  keep 1 of every (decim+1) samples.
- frame_ack  in  1  display has consumed the frame.
- wr_en  out  1  sample RAM write strobe.
- wr_addr  out  ADDR_W  sample RAM write address.
- wr_data  out  8  sample RAM write data.
- frame_ready  out  1  a complete frame is in RAM.
- auto_fired  out  1  the current or last frame was force-triggered.
- busy  out  1  high in WAIT_TRIG or CAPTURE.

## Operation
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE:
  - Mode 0 or 1 → WAIT_TRIG.
  - Mode 2 with an arm pulse → WAIT_TRIG.
  - Mode 3 → stay in IDLE.
- On entry to WAIT_TRIG:
  - Latch decim into decim_q.
  - Clear the decimation counter, the timeout counter, prev_valid and auto_fired.
- Accepted sample: sample_valid=1 with decimation counter = 0.
  - Every sample_valid advances the counter, which wraps from decim_q to 0.
  - With decim_q = 0, every valid sample is accepted.
- WAIT_TRIG, for each accepted sample cur (prev = previous accepted sample):
  - First accepted sample after entry: load prev only; no trigger check.
  - Rising trigger: prev < trig_level and cur >= trig_level.
  - Falling trigger: prev > trig_level and cur <= trig_level.
  - Mode 0 only: increment the timeout counter. When it reaches AUTO_TIMEOUT with no real trigger, force a trigger on cur and set auto_fired.
  - On trigger: write cur at address 0, then → CAPTURE.
  - A real trigger on the same sample as the timeout wins; auto_fired stays 0.
- CAPTURE:
  - Each accepted sample is written at the next address.
  - When address 2^ADDR_W−1 is written → DONE, with frame_ready=1.
  - Address never wraps within a frame.
- DONE:
  - Samples are ignored.
  - frame_ready holds until frame_ack=1 is sampled.
  - On ack, modes 0 and 1 → WAIT_TRIG; modes 2 and 3 → IDLE.
- trig_mode=3 in WAIT_TRIG or CAPTURE aborts to IDLE on the next edge. No further writes occur and frame_ready stays 0.
- Ignored inputs:
  - arm outside IDLE.
  - frame_ack outside DONE.
  - Mode changes other than to stop; these take effect at the next IDLE or DONE exit.
- Trigger comparisons are 8-bit unsigned; no hysteresis.

## Timing
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_ready=0, auto_fired=0, busy=0, state=IDLE.
- An accepted sample arriving in cycle N produces wr_en=1 for exactly cycle N+1, with wr_addr and wr_data valid in that cycle.
- frame_ready rises in the cycle after the last wr_en pulse.
- frame_ack sampled high in cycle M:
  - frame_ready=0 in cycle M+1.
  - State WAIT_TRIG or IDLE in cycle M+1.
  - busy=1 in cycle M+1 if the state is WAIT_TRIG.
- busy rises the cycle after the IDLE exit condition. It falls the cycle after the transition to DONE or IDLE.
- At most one write per sample_valid; back-to-back sample_valid is supported.
- Asserting RST_N mid-frame returns all outputs to reset values immediately. The partial frame is discarded.

## Test plan
Bench uses ADDR_W=4 and AUTO_TIMEOUT=32.
- Rising trigger: mode 1, decim 0, trig_level 0x80, edge 0, ramp 0x70,0x78,0x80,0x88,… → first write addr 0 data 0x80, then 16 writes to addresses 0..15, frame_ready=1, auto_fired=0. Ack → busy=1 again.
- Falling edge: edge 1, level 0x40, samples 0x50,0x48,0x40,0x38 → addr 0 gets 0x40. Sequence 0x40,0x40 alone does not trigger.
- Auto timeout: mode 0, constant 0x10, level 0x80 → the 32nd accepted sample is written at addr 0 and auto_fired=1. The same run in mode 1 produces no writes.
- Single shot: mode 2 with no arm → no writes. Arm pulse plus ramp → one frame. Ack → IDLE and busy=0; a further ramp gives no writes until the next arm.
- Decimation: decim 2, samples 0,1,2,3,… with level 5, rising → accepted samples 0,3,6,…; addr 0 gets 6, addr 1 gets 9.
- Abort and reset: mode set to 3 after the 5th capture write → no more writes, frame_ready=0, busy=0. RST_N low mid-capture → all outputs 0 immediately.

Source files
------------

// File: rtl/scope_capture_if.sv
// scope_capture_if
//   Bundles the capture sequencer's stream, control, sample-RAM write and
//   display-handshake signals.
//   Ports (by modport):
//     slave  - the capture sequencer: consumes sample_valid/sample_data,
//              trig_level/trig_edge/trig_mode, arm, decim and frame_ack;
//              drives wr_en/wr_addr/wr_data, frame_ready, auto_fired and busy.
//     master - the surrounding system (ADC stream, controls, display side).
interface scope_capture_if #(
  parameter int ADDR_W = 8
);
  logic              sample_valid;
  logic [7:0]        sample_data;
  logic [7:0]        trig_level;
  logic              trig_edge;
  logic [1:0]        trig_mode;
  logic              arm;
  logic [3:0]        decim;
  logic              frame_ack;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_ready;
  logic              auto_fired;
  logic              busy;

  modport master (
    output sample_valid, sample_data, trig_level, trig_edge, trig_mode,
           arm, decim, frame_ack,
    input  wr_en, wr_addr, wr_data, frame_ready, auto_fired, busy
  );

  modport slave (
    input  sample_valid, sample_data, trig_level, trig_edge, trig_mode,
           arm, decim, frame_ack,
    output wr_en, wr_addr, wr_data, frame_ready, auto_fired, busy
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl
//   Capture sequencer for the oscilloscope datapath. Decimates the 8-bit ADC
//   sample stream, waits for an edge trigger (or a forced trigger in auto
//   mode), writes one frame of 2^ADDR_W samples into the display sample RAM
//   and then holds frame_ready until the display acknowledges it.
//   Ports:
//     CLK_50M - system clock
//     RST_N   - asynchronous active-low reset
//     bus     - scope_capture_if.slave: sample stream, trigger/mode controls,
//               arm, decim, frame_ack in; RAM write strobe/address/data,
//               frame_ready, auto_fired, busy out (all registered).
module scope_capture_ctrl #(
  parameter int          ADDR_W       = 8,
  parameter logic [15:0] AUTO_TIMEOUT = 16'd1000
) (
  input  logic           CLK_50M,
  input  logic           RST_N,
  scope_capture_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        decim_q, decim_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [7:0]        prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              auto_fired_q, auto_fired_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_ready_q, frame_ready_d;
  logic              busy_q, busy_d;

  logic              in_acq;
  logic              accept;
  logic              real_trig;
  logic              timeout_hit;
  logic [15:0]       tcnt_inc;
  logic [ADDR_W-1:0] addr_next;
  logic              enter_wait;

  // Unsigned edge detect between two consecutive accepted samples.
  function automatic logic edge_hit(input logic [7:0] prev, input logic [7:0] cur,
                                    input logic [7:0] lvl, input logic falling);
    if (falling) return (prev > lvl) && (cur <= lvl);
    else         return (prev < lvl) && (cur >= lvl);
  endfunction

  assign in_acq      = (state_q == ST_WAIT) || (state_q == ST_CAPT);
  assign accept      = in_acq && bus.sample_valid && (dcnt_q == 4'd0);
  assign real_trig   = prev_valid_q &&
                       edge_hit(prev_q, bus.sample_data, bus.trig_level, bus.trig_edge);
  assign tcnt_inc    = tcnt_q + 16'd1;
  // Mode is latched on WAIT_TRIG entry, so a live mode change never arms the timeout.
  assign timeout_hit = (mode_q == MODE_AUTO) && (tcnt_inc == AUTO_TIMEOUT);
  assign addr_next   = wr_addr_q + ADDR_W'(1);

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    decim_d       = decim_q;
    dcnt_d        = dcnt_q;
    tcnt_d        = tcnt_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    auto_fired_d  = auto_fired_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_ready_d = frame_ready_q;
    enter_wait    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((bus.trig_mode == MODE_AUTO) || (bus.trig_mode == MODE_NORMAL) ||
            ((bus.trig_mode == MODE_SINGLE) && bus.arm)) begin
          state_d    = ST_WAIT;
          enter_wait = 1'b1;
        end
      end

      ST_WAIT, ST_CAPT: begin
        if (bus.trig_mode == MODE_STOP) begin
          // Stop has priority over any sample arriving in the same cycle.
          state_d = ST_IDLE;
        end else begin
          if (bus.sample_valid)
            dcnt_d = (dcnt_q == decim_q) ? 4'd0 : dcnt_q + 4'd1;

          if (accept && (state_q == ST_WAIT)) begin
            prev_d       = bus.sample_data;
            prev_valid_d = 1'b1;
            if (mode_q == MODE_AUTO)
              tcnt_d = tcnt_inc;
            if (real_trig || timeout_hit) begin
              wr_en_d      = 1'b1;
              wr_addr_d    = '0;
              wr_data_d    = bus.sample_data;
              // A genuine edge on the timeout sample is not reported as forced.
              auto_fired_d = ~real_trig;
              state_d      = ST_CAPT;
            end
          end else if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_next;
            wr_data_d = bus.sample_data;
            if (addr_next == {ADDR_W{1'b1}})
              state_d = ST_DONE;
          end
        end
      end

      default: begin
        // ST_DONE: frame_ready rises one cycle after the last write and an
        // ack is only honoured once it is visible to the display.
        frame_ready_d = 1'b1;
        if (frame_ready_q && bus.frame_ack) begin
          frame_ready_d = 1'b0;
          if ((bus.trig_mode == MODE_AUTO) || (bus.trig_mode == MODE_NORMAL)) begin
            state_d    = ST_WAIT;
            enter_wait = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    if (enter_wait) begin
      mode_d       = bus.trig_mode;
      decim_d      = bus.decim;
      dcnt_d       = 4'd0;
      tcnt_d       = 16'd0;
      prev_valid_d = 1'b0;
      auto_fired_d = 1'b0;
    end

    busy_d = (state_d == ST_WAIT) || (state_d == ST_CAPT);
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_STOP;
      decim_q       <= 4'd0;
      dcnt_q        <= 4'd0;
      tcnt_q        <= 16'd0;
      prev_q        <= 8'd0;
      prev_valid_q  <= 1'b0;
      auto_fired_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'd0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      decim_q       <= decim_d;
      dcnt_q        <= dcnt_d;
      tcnt_q        <= tcnt_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      auto_fired_q  <= auto_fired_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.auto_fired  = auto_fired_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl
//   Scoreboard bench for scope_capture_ctrl with ADDR_W=4, AUTO_TIMEOUT=32.
//   Stimulus tasks push the expected RAM writes (address, data, cycle);
//   a monitor pops and compares each write strobe.
module tb_scope_capture_ctrl;
  localparam int          ADDR_W  = 4;
  localparam logic [15:0] AUTO_TO = 16'd32;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_STOP   = 2'd3;

  logic CLK_50M = 1'b0;
  logic RST_N   = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  scope_capture_if #(.ADDR_W(ADDR_W)) bus ();

  scope_capture_ctrl #(.ADDR_W(ADDR_W), .AUTO_TIMEOUT(AUTO_TO)) dut (
    .CLK_50M (CLK_50M),
    .RST_N   (RST_N),
    .bus     (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge CLK_50M) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge CLK_50M) begin
    if (RST_N && bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
        check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Main-thread activity sits 1 ns after the falling edge, behind the monitor.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge CLK_50M);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit exp_wr, input int addr);
    exp_t e;
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    if (exp_wr) begin
      e.addr = ADDR_W'(addr);
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic ack_frame();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  // Ramp 0x70,0x78,...: rising through 0x80 triggers on the third sample.
  task automatic ramp_frame(input bit exp_wr);
    for (int k = 0; k < 18; k++)
      send(8'(8'h70 + 8 * k), exp_wr && (k >= 2), k - 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fall_seq [9];
    fall_seq = '{8'h40, 8'h40, 8'h50, 8'h48, 8'h40, 8'h38, 8'h30, 8'h28, 8'h20};

    bus.sample_valid = 1'b0;
    bus.sample_data  = 8'd0;
    bus.trig_level   = 8'h80;
    bus.trig_edge    = 1'b0;
    bus.trig_mode    = MODE_STOP;
    bus.arm          = 1'b0;
    bus.decim        = 4'd0;
    bus.frame_ack    = 1'b0;

    // Reset state
    tick(3);
    check("rst_wr_en",       32'(bus.wr_en),       32'd0);
    check("rst_wr_addr",     32'(bus.wr_addr),     32'd0);
    check("rst_wr_data",     32'(bus.wr_data),     32'd0);
    check("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
    check("rst_auto_fired",  32'(bus.auto_fired),  32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    RST_N = 1'b1;
    tick(2);
    check("stop_idle_busy", 32'(bus.busy), 32'd0);

    // Rising trigger, normal mode
    bus.trig_mode = MODE_NORMAL;
    tick(2);
    check("rise_busy", 32'(bus.busy), 32'd1);
    ramp_frame(1'b1);
    check("rise_ready_late", 32'(bus.frame_ready), 32'd0);
    tick();
    check("rise_ready", 32'(bus.frame_ready), 32'd1);
    check("rise_auto",  32'(bus.auto_fired),  32'd0);
    check("rise_busy_done", 32'(bus.busy), 32'd0);
    check("rise_q_empty", 32'(exp_q.size()), 32'd0);
    send(8'h99, 1'b0, 0);
    check("done_hold_ready", 32'(bus.frame_ready), 32'd1);
    ack_frame();
    check("ack_ready", 32'(bus.frame_ready), 32'd0);
    check("ack_busy",  32'(bus.busy),        32'd1);

    // Falling edge (already waiting, normal mode), then abort mid-capture
    bus.trig_edge  = 1'b1;
    bus.trig_level = 8'h40;
    for (int i = 0; i < 9; i++)
      send(fall_seq[i], i >= 4, i - 4);
    bus.trig_mode = MODE_STOP;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++)
      send(8'h10, 1'b0, 0);
    check("abort_ready", 32'(bus.frame_ready), 32'd0);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);

    // Auto timeout: 32nd accepted sample forces the trigger
    bus.trig_edge  = 1'b0;
    bus.trig_level = 8'h80;
    bus.trig_mode  = MODE_AUTO;
    tick(2);
    for (int i = 0; i < 31; i++)
      send(8'h10, 1'b0, 0);
    send(8'h10, 1'b1, 0);
    check("auto_fired", 32'(bus.auto_fired), 32'd1);
    for (int j = 1; j < 16; j++)
      send(8'h10, 1'b1, j);
    tick();
    check("auto_ready", 32'(bus.frame_ready), 32'd1);
    bus.trig_mode = MODE_STOP;
    ack_frame();
    check("auto_ack_ready", 32'(bus.frame_ready), 32'd0);
    check("auto_ack_busy",  32'(bus.busy),        32'd0);
    check("auto_fired_kept", 32'(bus.auto_fired), 32'd1);

    // Same constant input in normal mode never triggers
    bus.trig_mode = MODE_NORMAL;
    tick(2);
    for (int i = 0; i < 40; i++)
      send(8'h10, 1'b0, 0);
    check("norm_auto_clr", 32'(bus.auto_fired), 32'd0);
    check("norm_busy",     32'(bus.busy),       32'd1);
    bus.trig_mode = MODE_STOP;
    tick();

    // Real edge on the timeout sample wins
    bus.trig_mode = MODE_AUTO;
    tick(2);
    for (int i = 0; i < 31; i++)
      send(8'h10, 1'b0, 0);
    send(8'h90, 1'b1, 0);
    check("coinc_auto", 32'(bus.auto_fired), 32'd0);
    bus.trig_mode = MODE_STOP;
    tick();
    check("coinc_q_empty", 32'(exp_q.size()), 32'd0);

    // Single shot
    bus.trig_mode = MODE_SINGLE;
    tick(3);
    check("single_noarm_busy", 32'(bus.busy), 32'd0);
    ramp_frame(1'b0);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("single_arm_busy", 32'(bus.busy), 32'd1);
    ramp_frame(1'b1);
    tick();
    check("single_ready", 32'(bus.frame_ready), 32'd1);
    ack_frame();
    check("single_ack_ready", 32'(bus.frame_ready), 32'd0);
    check("single_ack_busy",  32'(bus.busy),        32'd0);
    ramp_frame(1'b0);
    check("single_rearm_busy", 32'(bus.busy), 32'd0);
    check("single_q_empty", 32'(exp_q.size()), 32'd0);

    // Decimation: keep 1 of 3, trigger at level 5 on sample 6
    bus.decim      = 4'd2;
    bus.trig_level = 8'd5;
    bus.trig_mode  = MODE_NORMAL;
    tick(2);
    for (int s = 0; s < 52; s++)
      send(8'(s), (s % 3 == 0) && (s >= 6), (s - 6) / 3);
    tick();
    check("decim_ready", 32'(bus.frame_ready), 32'd1);
    bus.trig_mode = MODE_STOP;
    ack_frame();
    check("decim_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-capture
    bus.decim      = 4'd0;
    bus.trig_level = 8'h80;
    bus.trig_mode  = MODE_NORMAL;
    tick(2);
    for (int k = 0; k < 7; k++)
      send(8'(8'h70 + 8 * k), k >= 2, k - 2);
    RST_N = 1'b0;
    #1;
    check("arst_wr_en",       32'(bus.wr_en),       32'd0);
    check("arst_wr_addr",     32'(bus.wr_addr),     32'd0);
    check("arst_wr_data",     32'(bus.wr_data),     32'd0);
    check("arst_frame_ready", 32'(bus.frame_ready), 32'd0);
    check("arst_auto_fired",  32'(bus.auto_fired),  32'd0);
    check("arst_busy",        32'(bus.busy),        32'd0);
    bus.trig_mode = MODE_STOP;
    tick(2);
    RST_N = 1'b1;
    tick(2);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
